// File: rtl/conv3d_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv3d_pkg                                                                 |
// | Shared widths, FSM state encoding and derived-dimension helpers.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package conv3d_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic first_tap;
        logic last_tap;
        logic last_all;
    } tap_flags_t;

    function automatic int out_dim(input int in_dim, input int k, input int pad, input int str);
        return (in_dim + 2 * pad - k) / str + 1;
    endfunction

    function automatic int taps(input int c_in, input int k_d, input int k_h, input int k_w);
        return c_in * k_d * k_h * k_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv3d_skid_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv3d_skid_fifo                                                           |
// | Two-entry FIFO holding operand pairs plus tap flags.                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conv3d_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == 2'd2);
    assign empty  = (r_count == 2'd0);
    assign count  = r_count;
    assign head   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv3d_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | conv3d_operand_sequencer                                                   |
// | Walks the 3D conv loop nest, reads input/weight memories, streams pairs.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module conv3d_operand_sequencer #(
    parameter int DATA_W = conv3d_pkg::DATA_W,
    parameter int ADDR_W = conv3d_pkg::ADDR_W,
    parameter int C_IN   = 2,
    parameter int C_OUT  = 2,
    parameter int IN_D   = 4,
    parameter int IN_H   = 5,
    parameter int IN_W   = 6,
    parameter int K_D    = 3,
    parameter int K_H    = 2,
    parameter int K_W    = 2,
    parameter int PAD_D  = 1,
    parameter int PAD_H  = 0,
    parameter int PAD_W  = 1,
    parameter int STR_D  = 1,
    parameter int STR_H  = 1,
    parameter int STR_W  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0] in_rd_data,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    input  logic [DATA_W-1:0] w_rd_data,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] input_data,
    output logic [DATA_W-1:0] weight_data,
    output logic              first_tap,
    output logic              last_tap,
    output logic              last_all
);
    import conv3d_pkg::*;

    localparam int OD     = out_dim(IN_D, K_D, PAD_D, STR_D);
    localparam int OH     = out_dim(IN_H, K_H, PAD_H, STR_H);
    localparam int OW     = out_dim(IN_W, K_W, PAD_W, STR_W);
    localparam int FIFO_W = 2 * DATA_W + 3;

    localparam logic [CNT_W-1:0] OC_MAX = CNT_W'(C_OUT - 1);
    localparam logic [CNT_W-1:0] OD_MAX = CNT_W'(OD - 1);
    localparam logic [CNT_W-1:0] OH_MAX = CNT_W'(OH - 1);
    localparam logic [CNT_W-1:0] OW_MAX = CNT_W'(OW - 1);
    localparam logic [CNT_W-1:0] IC_MAX = CNT_W'(C_IN - 1);
    localparam logic [CNT_W-1:0] KD_MAX = CNT_W'(K_D - 1);
    localparam logic [CNT_W-1:0] KH_MAX = CNT_W'(K_H - 1);
    localparam logic [CNT_W-1:0] KW_MAX = CNT_W'(K_W - 1);

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_post_rst;
    logic [CNT_W-1:0] r_oc, r_od, r_oh, r_ow, r_ic, r_kd, r_kh, r_kw;
    logic             r_pend;
    logic             r_pad;
    tap_flags_t       r_flags;

    tap_flags_t        w_flags;
    logic              w_c_kw, w_c_kh, w_c_kd, w_c_ic, w_c_ow, w_c_oh, w_c_od, w_c_oc;
    int                w_id, w_ih, w_iw;
    logic              w_pad;
    logic [ADDR_W-1:0] w_in_addr, w_w_addr;
    logic              w_accept, w_credit, w_issue, w_pop;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_full, w_fifo_empty;
    logic [DATA_W-1:0] w_in_operand;
    logic [FIFO_W-1:0] w_push_data, w_head;

    // Carry chain: w_c_X is set when X and every inner counter are at their max.
    assign w_c_kw = (r_kw == KW_MAX);
    assign w_c_kh = w_c_kw && (r_kh == KH_MAX);
    assign w_c_kd = w_c_kh && (r_kd == KD_MAX);
    assign w_c_ic = w_c_kd && (r_ic == IC_MAX);
    assign w_c_ow = w_c_ic && (r_ow == OW_MAX);
    assign w_c_oh = w_c_ow && (r_oh == OH_MAX);
    assign w_c_od = w_c_oh && (r_od == OD_MAX);
    assign w_c_oc = w_c_od && (r_oc == OC_MAX);

    assign w_flags.first_tap = (r_ic == '0) && (r_kd == '0) && (r_kh == '0) && (r_kw == '0);
    assign w_flags.last_tap  = w_c_ic;
    assign w_flags.last_all  = w_c_oc;

    always_comb begin
        w_id      = int'(r_od) * STR_D - PAD_D + int'(r_kd);
        w_ih      = int'(r_oh) * STR_H - PAD_H + int'(r_kh);
        w_iw      = int'(r_ow) * STR_W - PAD_W + int'(r_kw);
        w_pad     = (w_id < 0) || (w_id >= IN_D) || (w_ih < 0) || (w_ih >= IN_H)
                 || (w_iw < 0) || (w_iw >= IN_W);
        w_in_addr = ADDR_W'(((int'(r_ic) * IN_D + w_id) * IN_H + w_ih) * IN_W + w_iw);
        w_w_addr  = ADDR_W'((((int'(r_oc) * C_IN + int'(r_ic)) * K_D + int'(r_kd)) * K_H
                    + int'(r_kh)) * K_W + int'(r_kw));
    end

    // Tap 0 issues in the accepting cycle so the first beat lands two cycles after start.
    // Credit: fifo_count + inflight < 2, with a same-cycle pop releasing one slot.
    assign w_pop    = valid_out && ready_in;
    assign w_credit = w_pop || (!w_fifo_full && !((w_fifo_count == 2'd1) && r_pend));
    assign w_accept = (r_state == IDLE) && start && !r_post_rst;
    assign w_issue  = w_accept || ((r_state == RUN) && w_credit);

    assign in_rd_en   = w_issue && !w_pad;
    assign in_rd_addr = in_rd_en ? w_in_addr : '0;
    assign w_rd_en    = w_issue;
    assign w_rd_addr  = w_issue ? w_w_addr : '0;
    assign busy       = r_busy;
    assign done       = r_done;

    assign w_in_operand = r_pad ? '0 : in_rd_data;
    assign w_push_data  = {w_in_operand, w_rd_data, r_flags};

    conv3d_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_pend),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_fifo_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign valid_out = !w_fifo_empty;
    assign {input_data, weight_data, first_tap, last_tap, last_all} = valid_out ? w_head : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_post_rst <= 1'b1;
            r_oc <= '0; r_od <= '0; r_oh <= '0; r_ow <= '0;
            r_ic <= '0; r_kd <= '0; r_kh <= '0; r_kw <= '0;
            r_pend     <= 1'b0;
            r_pad      <= 1'b0;
            r_flags    <= '0;
        end else begin
            r_post_rst <= 1'b0;
            r_done     <= 1'b0;
            r_pend     <= w_issue;
            if (w_issue) begin
                r_pad   <= w_pad;
                r_flags <= w_flags;
                r_kw    <= w_c_kw ? '0 : r_kw + 1'b1;
                if (w_c_kw) r_kh <= w_c_kh ? '0 : r_kh + 1'b1;
                if (w_c_kh) r_kd <= w_c_kd ? '0 : r_kd + 1'b1;
                if (w_c_kd) r_ic <= w_c_ic ? '0 : r_ic + 1'b1;
                if (w_c_ic) r_ow <= w_c_ow ? '0 : r_ow + 1'b1;
                if (w_c_ow) r_oh <= w_c_oh ? '0 : r_oh + 1'b1;
                if (w_c_oh) r_od <= w_c_od ? '0 : r_od + 1'b1;
                if (w_c_od) r_oc <= w_c_oc ? '0 : r_oc + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= w_flags.last_all ? DRAIN : RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_issue && w_flags.last_all) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (!r_pend && w_pop && (w_fifo_count == 2'd1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3d_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_conv3d_operand_sequencer                                                |
// | Directed table vectors plus loop-nest reference stream for the sequencer.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_conv3d_operand_sequencer;

    localparam logic [31:0] IBASE = 32'hA000_0000;
    localparam logic [31:0] WBASE = 32'h5000_0000;
    localparam int          NBEATS = 5376;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, in_rd_en, w_rd_en, valid_out;
    logic        ready_in;
    logic [15:0] in_rd_addr, w_rd_addr;
    logic [31:0] in_rd_data = '0;
    logic [31:0] w_rd_data = '0;
    logic [31:0] input_data, weight_data;
    logic        first_tap, last_tap, last_all;

    conv3d_operand_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .in_rd_en    (in_rd_en),
        .in_rd_addr  (in_rd_addr),
        .in_rd_data  (in_rd_data),
        .w_rd_en     (w_rd_en),
        .w_rd_addr   (w_rd_addr),
        .w_rd_data   (w_rd_data),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .input_data  (input_data),
        .weight_data (weight_data),
        .first_tap   (first_tap),
        .last_tap    (last_tap),
        .last_all    (last_all)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: content encodes the address; unread input returns junk.
    always @(posedge clk) begin
        in_rd_data <= in_rd_en ? IBASE + 32'(in_rd_addr) : 32'hBAD0_0000 + 32'(cyc);
        w_rd_data  <= w_rd_en  ? WBASE + 32'(w_rd_addr)  : 32'hDEAD_0000 + 32'(cyc);
    end

    int total = 0;
    int bad = 0;
    logic [66:0] rx[$];
    logic [66:0] exp_q[$];
    int first_valid_cyc, last_beat_cyc, done_cyc, done_cnt = 0, start_cyc;
    logic busy_at_done;
    int stall_req = 0;
    logic stall_win = 1'b0;
    logic rand_mode = 1'b0;
    int stall_valid_cnt, stall_reads, stall_viol;
    logic stall_prev = 1'b0;
    logic [66:0] prev_head;

    initial begin
        ready_in = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_req > 0) begin
                ready_in  = 1'b0;
                stall_win = 1'b1;
                stall_req = stall_req - 1;
            end else begin
                stall_win = 1'b0;
                ready_in  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (valid_out && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (valid_out && ready_in) begin
                rx.push_back({input_data, weight_data, first_tap, last_tap, last_all});
                last_beat_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy;
            end
            if (stall_win) begin
                if (valid_out) stall_valid_cnt++;
                if (in_rd_en || w_rd_en) stall_reads++;
                if (stall_prev && prev_head !== {input_data, weight_data, first_tap, last_tap, last_all})
                    stall_viol++;
                prev_head  = {input_data, weight_data, first_tap, last_tap, last_all};
                stall_prev = valid_out;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {24'd0, busy, done, in_rd_en, in_rd_addr, w_rd_en, w_rd_addr, valid_out,
                input_data, weight_data, first_tap, last_tap, last_all};
    endfunction

    task automatic build_expected();
        exp_q.delete();
        for (int oc = 0; oc < 2; oc++)
        for (int od = 0; od < 4; od++)
        for (int oh = 0; oh < 4; oh++)
        for (int ow = 0; ow < 7; ow++)
        for (int ic = 0; ic < 2; ic++)
        for (int kd = 0; kd < 3; kd++)
        for (int kh = 0; kh < 2; kh++)
        for (int kw = 0; kw < 2; kw++) begin
            int id = od - 1 + kd;
            int ih = oh + kh;
            int iw = ow - 1 + kw;
            logic pad = (id < 0) || (id >= 4) || (ih >= 5) || (iw < 0) || (iw >= 6);
            int ia = ((ic * 4 + id) * 5 + ih) * 6 + iw;
            int wa = (((oc * 2 + ic) * 3 + kd) * 2 + kh) * 2 + kw;
            logic f = (ic == 0) && (kd == 0) && (kh == 0) && (kw == 0);
            logic l = (ic == 1) && (kd == 2) && (kh == 1) && (kw == 1);
            logic la = l && (oc == 1) && (od == 3) && (oh == 3) && (ow == 6);
            exp_q.push_back({pad ? 32'd0 : IBASE + 32'(ia), WBASE + 32'(wa), f, l, la});
        end
    endtask

    task automatic check_stream(input string name);
        int first_bad = -1;
        int n = (rx.size() < exp_q.size()) ? rx.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (first_bad < 0 && rx[i] !== exp_q[i]) first_bad = i;
        if (first_bad < 0 && rx.size() != exp_q.size()) first_bad = n;
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s: beat %0d of %0d got %0h expected %0h", name, first_bad,
                     rx.size(), (first_bad < rx.size()) ? rx[first_bad] : 67'd0,
                     exp_q[first_bad]);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_rx(input int n, input string name);
        for (int i = 0; i < 30000 && rx.size() < n; i++) @(posedge clk);
        chk(name, 128'(rx.size() >= n), 128'd1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 30000 && done_cnt == d0; i++) @(posedge clk);
        repeat (10) @(posedge clk);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] in_d;
        logic [31:0] w_d;
        logic        f;
        logic        l;
        logic        la;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int d0, n_rx, cnt_l, cnt_la;

        tbl[0] = '{0,    32'd0,        WBASE + 0,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{4,    32'd0,        WBASE + 4,  1'b0, 1'b0, 1'b0};
        tbl[2] = '{5,    IBASE + 0,    WBASE + 5,  1'b0, 1'b0, 1'b0};
        tbl[3] = '{23,   IBASE + 156,  WBASE + 23, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{24,   32'd0,        WBASE + 0,  1'b1, 1'b0, 1'b0};
        tbl[5] = '{29,   IBASE + 1,    WBASE + 5,  1'b0, 1'b0, 1'b0};
        tbl[6] = '{5352, IBASE + 83,   WBASE + 24, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{5375, 32'd0,        WBASE + 47, 1'b0, 1'b1, 1'b1};
        build_expected();

        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", all_outs(), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Run A: ready held high
        rx.delete();
        first_valid_cyc = -1;
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);
        chk("first_latency", 128'(first_valid_cyc - start_cyc), 128'd2);
        chk("beat_count", 128'(rx.size()), 128'(NBEATS));
        chk("one_per_cycle", 128'(last_beat_cyc - first_valid_cyc), 128'(NBEATS - 1));
        chk("done_once", 128'(done_cnt - d0), 128'd1);
        chk("done_timing", 128'(done_cyc - last_beat_cyc), 128'd1);
        chk("busy_at_done", 128'(busy_at_done), 128'd0);
        cnt_l = 0;
        cnt_la = 0;
        foreach (rx[i]) begin
            if (rx[i][1]) cnt_l++;
            if (rx[i][0]) cnt_la++;
        end
        chk("last_tap_count", 128'(cnt_l), 128'd224);
        chk("last_all_count", 128'(cnt_la), 128'd1);
        for (int k = 0; k < 8; k++)
            chk($sformatf("vec%0d_beat%0d", k, tbl[k].idx), 128'(rx[tbl[k].idx]),
                128'({tbl[k].in_d, tbl[k].w_d, tbl[k].f, tbl[k].l, tbl[k].la}));
        check_stream("stream_nostall");

        // Run B: ten-cycle stall after three beats
        rx.delete();
        d0 = done_cnt;
        pulse_start();
        wait_rx(3, "stall_wait3");
        @(posedge clk);
        stall_valid_cnt = 0;
        stall_reads     = 0;
        stall_viol      = 0;
        stall_req       = 10;
        wait_done(d0);
        chk("stall_valid_held", 128'(stall_valid_cnt), 128'd10);
        chk("stall_no_reads", 128'(stall_reads), 128'd0);
        chk("stall_head_stable", 128'(stall_viol), 128'd0);
        chk("stall_done_once", 128'(done_cnt - d0), 128'd1);
        check_stream("stream_stall");

        // Run C: random ready with extra start pulses mid-run
        rx.delete();
        d0 = done_cnt;
        @(posedge clk);
        rand_mode = 1'b1;
        pulse_start();
        wait_rx(100, "rand_wait100");
        pulse_start();
        wait_rx(2000, "rand_wait2000");
        pulse_start();
        wait_done(d0);
        @(posedge clk);
        rand_mode = 1'b0;
        repeat (20) @(posedge clk);
        chk("rand_done_once", 128'(done_cnt - d0), 128'd1);
        chk("rand_beat_count", 128'(rx.size()), 128'(NBEATS));
        check_stream("stream_random");

        // Run D: reset at beat 1000, then a clean restart
        rx.delete();
        pulse_start();
        wait_rx(1000, "rst_wait1000");
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("midrun_rst_outputs", all_outs(), 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_rx = rx.size();
        d0 = done_cnt;
        @(negedge clk);
        #2;
        chk("post_rst_outputs", all_outs(), 128'd0);
        repeat (30) @(posedge clk);
        chk("rst_no_done", 128'(done_cnt - d0), 128'd0);
        chk("rst_no_beats", 128'(rx.size() - n_rx), 128'd0);
        rx.delete();
        d0 = done_cnt;
        pulse_start();
        wait_done(d0);
        chk("restart_done_once", 128'(done_cnt - d0), 128'd1);
        check_stream("stream_restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
